// File: rtl/loopback_buffer_pkg.sv
// Shared constants for the USB CDC loopback byte buffer: FSM encoding and the
// default packet size / idle timeout used by the example top and its bench.
package loopback_buffer_pkg;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  localparam int IN_BULK_MAXPACKETSIZE = 8;
  localparam int LOOPBACK_TIMEOUT      = 1024;
  localparam int LOOPBACK_DEPTH        = 32;

endpackage

// File: rtl/loopback_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port, so the
// array maps onto iCE40 block RAM. Read data holds while rd_en_i is low.
module loopback_ram #(
  parameter int WORDS = 31,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem [WORDS];

  // Read-before-write on an address collision: the old byte is returned.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/loopback_buffer.sv
// Loopback byte buffer: collects host->device bytes and releases them towards
// the IN stream in packet-sized bursts, or after the OUT side has gone idle.
module loopback_buffer
  import loopback_buffer_pkg::*;
#(
  parameter int DEPTH     = LOOPBACK_DEPTH,
  parameter int THRESHOLD = IN_BULK_MAXPACKETSIZE,
  parameter int TIMEOUT   = LOOPBACK_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [7:0]             out_data_i,
  input  logic                   out_valid_i,
  output logic                   out_ready_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   state_o
);

  // Handshakes: a byte moves when valid && ready are both high at a rising
  // edge. in_valid_o never drops and in_data_o never changes until the byte
  // is taken; out_ready_o depends only on registered occupancy.

  localparam int AW        = $clog2(DEPTH);
  localparam int LW        = AW + 1;
  localparam int CW        = $clog2(TIMEOUT) + 1;
  localparam int RAM_WORDS = DEPTH - 1;

  localparam logic [AW-1:0] PTR_LAST  = AW'(RAM_WORDS - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L  = LW'(THRESHOLD);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] TRIGGER_C = CW'(TIMEOUT - 1);

  logic          state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] ram_cnt_q, ram_cnt_d;
  logic          out_vld_q, out_vld_d;
  logic          byp_sel_q;
  logic [7:0]    byp_q;
  logic [CW-1:0] idle_q, idle_d;
  logic          in_valid_q, in_valid_d;
  logic [LW-1:0] level_d;
  logic [7:0]    ram_q;

  logic wr, rd, load, ram_empty, ram_wr, ram_rd;

  // Output register is either the RAM read register or a bypass byte taken
  // straight from the OUT stream when the RAM has nothing queued.
  loopback_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (ram_wr),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (out_data_i),
    .rd_en_i   (ram_rd),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_q)
  );

  assign level_o = LW'(ram_cnt_q) + LW'(out_vld_q);

  always_comb begin
    wr        = out_valid_i && out_ready_o;
    rd        = in_valid_q && in_ready_i;
    ram_empty = (ram_cnt_q == '0);
    load      = (!out_vld_q || rd) && (!ram_empty || wr);
    ram_rd    = load && !ram_empty;
    ram_wr    = wr && !(load && ram_empty);

    ram_cnt_d = ram_cnt_q;
    if (ram_wr && !ram_rd) begin
      ram_cnt_d = ram_cnt_q + 1'b1;
    end else if (ram_rd && !ram_wr) begin
      ram_cnt_d = ram_cnt_q - 1'b1;
    end

    out_vld_d = load || (out_vld_q && !rd);
    level_d   = LW'(ram_cnt_d) + LW'(out_vld_d);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if ((level_d >= THRESH_L) || ((idle_q == TRIGGER_C) && (level_o != '0))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (level_d == '0) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Idle counter only advances while accumulating; it parks at TIMEOUT.
  always_comb begin
    if (wr || (level_o == '0) || ((state_q == ST_DRAIN) && (state_d == ST_ACCUM))) begin
      idle_d = '0;
    end else if ((state_q == ST_ACCUM) && (idle_q != TIMEOUT_C)) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end
  end

  always_comb begin
    out_ready_o = !full_o;
    full_o      = (level_o == DEPTH_L);
    empty_o     = (level_o == '0);
    state_o     = state_q;
    in_valid_o  = in_valid_q;
    in_data_o   = byp_sel_q ? byp_q : ram_q;
    // Valid is registered, so it follows the held byte one edge after DRAIN.
    in_valid_d  = (state_q == ST_DRAIN) && out_vld_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      byp_sel_q  <= 1'b1;
      byp_q      <= 8'h00;
      idle_q     <= '0;
      in_valid_q <= 1'b0;
    end else begin
      ram_cnt_q  <= ram_cnt_d;
      out_vld_q  <= out_vld_d;
      idle_q     <= idle_d;
      in_valid_q <= in_valid_d;
      if (ram_wr) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (load) begin
        byp_sel_q <= ram_empty;
        if (ram_empty) begin
          byp_q <= out_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_loopback_buffer.sv
// Directed bench for loopback_buffer: a FIFO scoreboard checks every byte and
// the occupancy flags each cycle, plus a vector table and corner sequences.
module tb_loopback_buffer;
  import loopback_buffer_pkg::*;

  localparam int DEPTH     = LOOPBACK_DEPTH;
  localparam int THRESHOLD = IN_BULK_MAXPACKETSIZE;
  localparam int TIMEOUT   = LOOPBACK_TIMEOUT;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk_i       = 1'b0;
  logic          rstn_i      = 1'b0;
  logic [7:0]    out_data_i  = 8'h00;
  logic          out_valid_i = 1'b0;
  logic          out_ready_o;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_ready_i  = 1'b0;
  logic [LW-1:0] level_o;
  logic          full_o;
  logic          empty_o;
  logic          state_o;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  loopback_buffer #(
    .DEPTH     (DEPTH),
    .THRESHOLD (THRESHOLD),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .state_o     (state_o)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_rx     = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic          wv;
    logic [7:0]    wd;
    logic          rr;
    logic [LW-1:0] lvl;
    logic          st;
    logic          iv;
    logic [7:0]    id;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h, required nothing (t=%0t)", name, act, $time);
  endtask

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr,
                              input logic [LW-1:0] lvl, input logic st,
                              input logic iv, input logic [7:0] id);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr; v.lvl = lvl; v.st = st; v.iv = iv; v.id = id;
    return v;
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic tick();
    logic       w, r, stall;
    logic [7:0] wd, rdat;
    #1;
    w     = rstn_i && out_valid_i && out_ready_o;
    r     = rstn_i && in_valid_o && in_ready_i;
    stall = rstn_i && in_valid_o && !in_ready_i;
    wd    = out_data_i;
    rdat  = in_data_o;
    @(posedge clk_i);
    #1;
    if (r) begin
      n_rx++;
      if (exp_q.size() == 0) fail_now("read_underflow", rdat);
      else check("read_data", rdat, exp_q.pop_front());
    end
    if (w) exp_q.push_back(wd);
    check("level", level_o, exp_q.size());
    check("out_ready", out_ready_o, exp_q.size() < DEPTH);
    check("full", full_o, exp_q.size() == DEPTH);
    check("empty", empty_o, exp_q.size() == 0);
    if (exp_q.size() == 0) check("idle_valid", in_valid_o, 0);
    else if (in_valid_o) check("front_data", in_data_o, exp_q[0]);
    if (stall && rstn_i) check("valid_held", in_valid_o, 1);
  endtask

  task automatic apply_reset();
    out_valid_i = 1'b0;
    in_ready_i  = 1'b0;
    out_data_i  = 8'h00;
    rstn_i      = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    exp_q.delete();
    rstn_i = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check({name, "_level"}, level_o, 0);
    check({name, "_state"}, state_o, ST_ACCUM);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, idx, base;
    logic acc;

    // 1. reset values
    apply_reset();
    #1;
    check("rst_out_ready", out_ready_o, 1);
    check("rst_in_valid", in_valid_o, 0);
    check("rst_in_data", in_data_o, 8'h00);
    check("rst_level", level_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_state", state_o, ST_ACCUM);

    // 2. seven bytes wait for the idle timeout
    base = n_rx;
    in_ready_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'(i);
      tick();
    end
    out_valid_i = 1'b0;
    seen = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (in_valid_o) seen++;
    end
    check("t2_state_before_timeout", state_o, ST_ACCUM);
    tick();
    if (in_valid_o) seen++;
    check("t2_valid_during_timeout", seen, 0);
    check("t2_state_at_timeout", state_o, ST_DRAIN);
    drain("t2_drain", 40);
    check("t2_rx_count", n_rx - base, 7);

    // 3. threshold drain, table-driven
    for (int k = 0; k < 8; k++) begin
      vecs[k] = mk(1'b1, 8'(8'h11 + k), 1'b1, LW'(k + 1), (k == 7) ? ST_DRAIN : ST_ACCUM, 1'b0, 8'h00);
    end
    vecs[8] = mk(1'b0, 8'h00, 1'b1, LW'(8), ST_DRAIN, 1'b1, 8'h11);
    for (int j = 1; j <= 8; j++) begin
      vecs[8 + j] = mk(1'b0, 8'h00, 1'b1, LW'(8 - j), (j == 8) ? ST_ACCUM : ST_DRAIN,
                       (j < 8), 8'(8'h11 + j));
    end
    base = n_rx;
    for (int v = 0; v < 17; v++) begin
      out_valid_i = vecs[v].wv;
      out_data_i  = vecs[v].wd;
      in_ready_i  = vecs[v].rr;
      tick();
      check("t3_level", level_o, vecs[v].lvl);
      check("t3_state", state_o, vecs[v].st);
      check("t3_in_valid", in_valid_o, vecs[v].iv);
      if (vecs[v].iv) check("t3_in_data", in_data_o, vecs[v].id);
    end
    check("t3_rx_count", n_rx - base, 8);

    // 4. fill to full with the IN side stalled, then release
    base = n_rx;
    in_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'(idx);
      acc = out_ready_o;
      tick();
      if (acc) idx++;
    end
    check("t4_accepted", idx, DEPTH);
    check("t4_full", full_o, 1);
    check("t4_out_ready", out_ready_o, 0);
    check("t4_level", level_o, DEPTH);
    in_ready_i = 1'b1;
    for (int c = 0; c < 200 && (idx < 40 || exp_q.size() != 0); c++) begin
      out_valid_i = (idx < 40);
      out_data_i  = 8'(idx);
      acc = out_ready_o && out_valid_i;
      tick();
      if (acc) idx++;
    end
    out_valid_i = 1'b0;
    check("t4_offered", idx, 40);
    check("t4_rx_count", n_rx - base, 40);
    check("t4_state", state_o, ST_ACCUM);

    // 5. steady write+read at level 5 in DRAIN
    in_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'(8'h50 + i);
      tick();
    end
    out_valid_i = 1'b0;
    tick();
    in_ready_i = 1'b1;
    repeat (3) tick();
    check("t5_level_start", level_o, 5);
    check("t5_state_start", state_o, ST_DRAIN);
    for (int i = 0; i < 10; i++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'(8'h60 + i);
      tick();
      check("t5_level_steady", level_o, 5);
      check("t5_valid_steady", in_valid_o, 1);
    end
    drain("t5_drain", 40);

    // 6. asynchronous reset in the middle of a drain
    in_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'(8'h30 + i);
      tick();
    end
    out_valid_i = 1'b0;
    tick();
    check("t6_pre_valid", in_valid_o, 1);
    check("t6_pre_level", level_o, 12);
    #2;
    rstn_i = 1'b0;
    #1;
    exp_q.delete();
    check("t6_async_valid", in_valid_o, 0);
    check("t6_async_level", level_o, 0);
    check("t6_async_empty", empty_o, 1);
    check("t6_async_state", state_o, ST_ACCUM);
    out_valid_i = 1'b1;
    out_data_i  = 8'hEE;
    tick();
    tick();
    out_valid_i = 1'b0;
    rstn_i = 1'b1;
    base = n_rx;
    in_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'(8'h41 + i);
      tick();
      if (i == 0) check("t6_first_write", level_o, 1);
    end
    drain("t6_drain", 40);
    check("t6_rx_count", n_rx - base, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
